// File: rtl/alu_md.sv
// alu_md: execute-stage ALU plus iterative multiply/divide engine writing HI/LO.
//   clk, rst            clock, asynchronous active-high reset
//   aluop, a, b         ALU opcode and operands (a[SHW-1:0] is the shift amount)
//   out, zero, oflow    combinational ALU result, result-is-zero, signed overflow
//   md_start, md_op     mult/div launch (00 mult, 01 multu, 10 div, 11 divu)
//   md_busy, md_done    engine running, one-cycle completion pulse
//   hi, lo              HI/LO registers
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       aluop,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             oflow,
    input  logic             md_start,
    input  logic [1:0]       md_op,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic                 busy_q, done_q, div_q, sa_q, sb_q, dz_q;
    logic [2*WIDTH-1:0]   p_q;
    logic [WIDTH-1:0]     m_q, hi_q, lo_q;

    logic [WIDTH-1:0]     sum, dif, mag_a, mag_b, quo, rem;
    logic                 sa, sb;
    logic [WIDTH:0]       acc, shr, dv;
    logic [2*WIDTH-1:0]   mul_p, div_p, prod;
    logic [WIDTH-1:0]     hi_d, lo_d;

    assign sum = a + b;
    assign dif = a - b;

    always_comb begin
        out   = '0;
        oflow = 1'b0;
        case (aluop)
            4'd0: begin
                out   = sum;
                oflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1:  out = a | b;
            4'd2:  out = WIDTH'($signed(a) < $signed(b));
            4'd3: begin
                out   = dif;
                oflow = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            4'd4:  out = WIDTH'({b[15:0], 16'h0000});
            4'd5:  out = a & b;
            4'd6:  out = a ^ b;
            4'd7:  out = ~(a | b);
            4'd8:  out = WIDTH'(a < b);
            4'd9:  out = b << a[SHW-1:0];
            4'd10: out = b >> a[SHW-1:0];
            4'd11: out = $signed(b) >>> a[SHW-1:0];
            4'd12: out = sum;
            4'd13: out = dif;
            4'd14: out = hi_q;
            default: out = lo_q;
        endcase
    end

    assign zero = (out == '0);

    // md_op[0] clear selects the signed variants
    assign sa    = ~md_op[0] & a[WIDTH-1];
    assign sb    = ~md_op[0] & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Multiply step: p_q = {partial product, remaining multiplier bits}
    assign acc   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    assign mul_p = {acc, p_q[WIDTH-1:1]};

    // Restoring divide step: p_q = {remainder, dividend bits / quotient bits}
    assign shr   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    assign dv    = shr - {1'b0, m_q};
    assign div_p = {dv[WIDTH] ? shr[WIDTH-1:0] : dv[WIDTH-1:0], p_q[WIDTH-2:0], ~dv[WIDTH]};

    // Sign fix-up; a zero divisor leaves the remainder equal to |a|, which
    // re-signs to a, while the quotient is forced to all ones
    assign prod = (sa_q ^ sb_q) ? -p_q : p_q;
    assign quo  = p_q[WIDTH-1:0];
    assign rem  = p_q[2*WIDTH-1:WIDTH];
    assign lo_d = div_q ? (dz_q ? '1 : ((sa_q ^ sb_q) ? -quo : quo)) : prod[WIDTH-1:0];
    assign hi_d = div_q ? (sa_q ? -rem : rem) : prod[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            dz_q    <= 1'b0;
            p_q     <= '0;
            m_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (md_start) begin
                    state_q <= CALC;
                    busy_q  <= 1'b1;
                    cnt_q   <= CW'(WIDTH);
                    div_q   <= md_op[1];
                    sa_q    <= sa;
                    sb_q    <= sb;
                    dz_q    <= (b == '0);
                    p_q     <= {{WIDTH{1'b0}}, mag_a};
                    m_q     <= mag_b;
                end
                CALC: begin
                    p_q   <= div_q ? div_p : mul_p;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_busy = busy_q;
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed self-checking bench for alu_md at WIDTH=32 and WIDTH=64.
module tb_alu_md;
    logic        clk, rst;
    logic [3:0]  aluop;
    logic [31:0] a, b, out, hi, lo;
    logic        zero, oflow, md_start, md_busy, md_done;
    logic [1:0]  md_op;

    logic [3:0]  aluop64;
    logic [63:0] a64, b64, out64, hi64, lo64;
    logic        zero64, oflow64, md_start64, md_busy64, md_done64;
    logic [1:0]  md_op64;

    int tests_run = 0;
    int tests_failed = 0;

    alu_md #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .aluop(aluop), .a(a), .b(b), .out(out),
        .zero(zero), .oflow(oflow), .md_start(md_start), .md_op(md_op),
        .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    alu_md #(.WIDTH(64)) dut64 (
        .clk(clk), .rst(rst), .aluop(aluop64), .a(a64), .b(b64), .out(out64),
        .zero(zero64), .oflow(oflow64), .md_start(md_start64), .md_op(md_op64),
        .md_busy(md_busy64), .md_done(md_done64), .hi(hi64), .lo(lo64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] x, y, o;
        logic        z, v;
    } alu_vec_t;

    alu_vec_t vecs[15] = '{
        '{"add_ovf",  4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1},
        '{"addu",     4'd12, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0},
        '{"sub_ovf",  4'd3,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1},
        '{"slt",      4'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0},
        '{"sltu",     4'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0},
        '{"sra",      4'd11, 32'h00000004, 32'h80000000, 32'hF8000000, 1'b0, 1'b0},
        '{"lui",      4'd4,  32'h00000000, 32'h00001234, 32'h12340000, 1'b0, 1'b0},
        '{"sub_zero", 4'd3,  32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0},
        '{"or",       4'd1,  32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0, 1'b0},
        '{"and",      4'd5,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1'b0},
        '{"xor",      4'd6,  32'h0000FFFF, 32'h00000F0F, 32'h0000F0F0, 1'b0, 1'b0},
        '{"nor",      4'd7,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0},
        '{"sll",      4'd9,  32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b0},
        '{"srl",      4'd10, 32'h00000004, 32'h80000000, 32'h08000000, 1'b0, 1'b0},
        '{"subu",     4'd13, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0}
    };

    // Launches one mult/div and counts busy cycles (bounded); leaves the
    // bench at the falling edge of the md_done cycle.
    task automatic md_go(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                         output int bc);
        @(negedge clk);
        md_op = op; a = x; b = y; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        bc = 0;
        while (md_busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; md_start = 1'b0; md_op = 2'b00; aluop = 4'd0; a = '0; b = '0;
        md_start64 = 1'b0; md_op64 = 2'b00; aluop64 = 4'd0; a64 = '0; b64 = '0;
        repeat (2) @(negedge clk);
        tests_run++;
        if ({hi, lo} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_hilo got %h exp 0", {hi, lo});
        end
        tests_run++;
        if ({md_busy, md_done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags got %b exp 00", {md_busy, md_done});
        end
        rst = 1'b0;
    endtask

    task automatic test_alu;
        foreach (vecs[i]) begin
            aluop = vecs[i].op; a = vecs[i].x; b = vecs[i].y;
            #1;
            tests_run++;
            if (out !== vecs[i].o) begin
                tests_failed++;
                $display("FAIL alu_%s out got %h exp %h", vecs[i].name, out, vecs[i].o);
            end
            tests_run++;
            if (zero !== vecs[i].z) begin
                tests_failed++;
                $display("FAIL alu_%s zero got %b exp %b", vecs[i].name, zero, vecs[i].z);
            end
            tests_run++;
            if (oflow !== vecs[i].v) begin
                tests_failed++;
                $display("FAIL alu_%s oflow got %b exp %b", vecs[i].name, oflow, vecs[i].v);
            end
        end
    endtask

    task automatic test_mult;
        int bc;
        md_go(2'b00, 32'hFFFFFFFD, 32'h7, bc);
        tests_run++;
        if (bc !== 33) begin
            tests_failed++;
            $display("FAIL mult_busy_cycles got %0d exp 33", bc);
        end
        tests_run++;
        if (md_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL mult_done got %b exp 1", md_done);
        end
        tests_run++;
        if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFEB) begin
            tests_failed++;
            $display("FAIL mult_neg got %h exp FFFFFFFFFFFFFFEB", {hi, lo});
        end
        @(negedge clk);
        tests_run++;
        if (md_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mult_done_pulse got %b exp 0", md_done);
        end
        aluop = 4'd14; #1;
        tests_run++;
        if (out !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL mfhi got %h exp FFFFFFFF", out);
        end
        md_go(2'b01, 32'hFFFFFFFF, 32'h2, bc);
        tests_run++;
        if ({hi, lo} !== 64'h00000001_FFFFFFFE) begin
            tests_failed++;
            $display("FAIL multu got %h exp 00000001FFFFFFFE", {hi, lo});
        end
    endtask

    task automatic test_div;
        int bc;
        md_go(2'b10, 32'hFFFFFFF9, 32'h2, bc);
        tests_run++;
        if ({hi, lo, bc} !== {32'hFFFFFFFF, 32'hFFFFFFFD, 32'd33}) begin
            tests_failed++;
            $display("FAIL div_neg got hi %h lo %h cyc %0d exp FFFFFFFF FFFFFFFD 33", hi, lo, bc);
        end
        md_go(2'b11, 32'd100, 32'd7, bc);
        tests_run++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin
            tests_failed++;
            $display("FAIL divu got hi %h lo %h exp 2 14", hi, lo);
        end
        md_go(2'b10, 32'd9, 32'd0, bc);
        tests_run++;
        if ({hi, lo} !== {32'd9, 32'hFFFFFFFF}) begin
            tests_failed++;
            $display("FAIL div_zero got hi %h lo %h exp 9 FFFFFFFF", hi, lo);
        end
        md_go(2'b11, 32'd9, 32'd0, bc);
        tests_run++;
        if ({hi, lo} !== {32'd9, 32'hFFFFFFFF}) begin
            tests_failed++;
            $display("FAIL divu_zero got hi %h lo %h exp 9 FFFFFFFF", hi, lo);
        end
        md_go(2'b10, 32'h80000000, 32'hFFFFFFFF, bc);
        tests_run++;
        if ({hi, lo} !== {32'd0, 32'h80000000}) begin
            tests_failed++;
            $display("FAIL div_ovf got hi %h lo %h exp 0 80000000", hi, lo);
        end
    endtask

    task automatic test_back_to_back;
        int bc;
        md_go(2'b01, 32'd3, 32'd5, bc);
        @(negedge clk);
        md_op = 2'b01; a = 32'd6; b = 32'd7; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0; a = 32'd100; b = 32'd3; aluop = 4'd15;
        repeat (5) @(negedge clk);
        tests_run++;
        if (out !== 32'd15) begin
            tests_failed++;
            $display("FAIL mflo_busy got %h exp 0000000F", out);
        end
        md_op = 2'b11; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        tests_run++;
        if ({hi, lo} !== {32'd0, 32'd15}) begin
            tests_failed++;
            $display("FAIL hilo_stale got %h exp 000000000000000F", {hi, lo});
        end
        bc = 6;
        while (md_busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        tests_run++;
        if ({hi, lo, bc} !== {32'd0, 32'd42, 32'd33}) begin
            tests_failed++;
            $display("FAIL restart_ignored got hi %h lo %h cyc %0d exp 0 2A 33", hi, lo, bc);
        end
        md_op = 2'b00; a = 32'hFFFFFFFD; b = 32'd7; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        tests_run++;
        if (md_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL start_in_done got busy %b exp 1", md_busy);
        end
        bc = 0;
        while (md_busy && bc < 200) begin
            bc++;
            @(negedge clk);
        end
        tests_run++;
        if ({hi, lo, bc} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 32'd33}) begin
            tests_failed++;
            $display("FAIL b2b_result got hi %h lo %h cyc %0d exp FFFFFFFF FFFFFFEB 33", hi, lo, bc);
        end
    endtask

    task automatic test_async_reset;
        int bc;
        @(negedge clk);
        md_op = 2'b11; a = 32'd100; b = 32'd7; md_start = 1'b1;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({md_busy, md_done, hi, lo} !== 66'h0) begin
            tests_failed++;
            $display("FAIL async_reset got busy %b done %b hi %h lo %h exp all 0", md_busy, md_done, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        md_go(2'b00, 32'hFFFFFFFD, 32'd7, bc);
        tests_run++;
        if ({hi, lo, bc} !== {32'hFFFFFFFF, 32'hFFFFFFEB, 32'd33}) begin
            tests_failed++;
            $display("FAIL post_reset_mult got hi %h lo %h cyc %0d exp FFFFFFFF FFFFFFEB 33", hi, lo, bc);
        end
    endtask

    task automatic test_width64;
        int bc;
        aluop64 = 4'd0; a64 = 64'h7FFFFFFFFFFFFFFF; b64 = 64'd1; #1;
        tests_run++;
        if ({out64, zero64, oflow64} !== {64'h8000000000000000, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL add64 got %h z %b v %b exp 8000000000000000 0 1", out64, zero64, oflow64);
        end
        @(negedge clk);
        md_op64 = 2'b01; a64 = '1; b64 = '1; md_start64 = 1'b1;
        @(negedge clk);
        md_start64 = 1'b0;
        bc = 0;
        while (md_busy64 && bc < 300) begin
            bc++;
            @(negedge clk);
        end
        tests_run++;
        if (bc !== 65) begin
            tests_failed++;
            $display("FAIL multu64_busy got %0d exp 65", bc);
        end
        tests_run++;
        if ({hi64, lo64, md_done64} !== {64'hFFFFFFFFFFFFFFFE, 64'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL multu64 got hi %h lo %h done %b exp FFFFFFFFFFFFFFFE 1 1", hi64, lo64, md_done64);
        end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_mult;
        test_div;
        test_back_to_back;
        test_async_reset;
        test_width64;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
